// File: rtl/lsu_mem_controller.sv
`default_nettype none
// lsu_mem_controller: sequences one RV32 load/store at a time onto a word-wide memory port with byte enables.
// Optional macro LSU_MISALIGNED_SPLIT_EN splits misaligned H/W accesses into two word accesses.
module lsu_mem_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REQ, S_WAIT, S_REQ2, S_WAIT2, S_FIN, S_FLT
  } state_t;

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam int BE_W = 8;
`else
  localparam int BE_W = 4;
`endif

  state_t                  r_state, w_nxt_state;
  logic                    r_is_store;
  logic [2:0]              r_funct3;
  logic [1:0]              r_off;
  logic [1:0]              w_off;
  logic [3:0]              w_size_mask;
  logic [BE_W-1:0]         w_be_sh;
  logic [BE_W*8-1:0]       w_wdata_sh;
  logic                    w_legal, w_misal, w_go, w_latch;
  logic                    w_nxt_req, w_nxt_we, w_nxt_done, w_nxt_fault;
  logic [ADDR_WIDTH-1:0]   w_nxt_addr;
  logic [3:0]              w_nxt_be;
  logic [DATA_WIDTH-1:0]   w_nxt_wdata, w_nxt_load;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic                    r_split;
  logic [3:0]              r_be_hi;
  logic [DATA_WIDTH-1:0]   r_wdata_hi, r_rdata_lo;
  logic                    w_cap_lo;
`endif

  function automatic logic [31:0] lsu_extend(input logic [63:0] raw, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] s;
    s = 32'(raw >> {off, 3'b000});
    case (f3)
      3'b000:  lsu_extend = {{24{s[7]}}, s[7:0]};
      3'b001:  lsu_extend = {{16{s[15]}}, s[15:0]};
      3'b100:  lsu_extend = {24'b0, s[7:0]};
      3'b101:  lsu_extend = {16'b0, s[15:0]};
      default: lsu_extend = s;
    endcase
  endfunction

  always_comb begin
    w_off = addr[1:0];
    case (funct3[1:0])
      2'b00:   w_size_mask = 4'b0001;
      2'b01:   w_size_mask = 4'b0011;
      default: w_size_mask = 4'b1111;
    endcase
    w_be_sh    = BE_W'(w_size_mask) << w_off;
    w_wdata_sh = (BE_W*8)'(store_data) << {w_off, 3'b000};
    if (is_store)
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else
      w_legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
    w_misal = ((funct3[1:0] == 2'b01) && w_off[0]) ||
              ((funct3[1:0] == 2'b10) && (w_off != 2'b00));
`ifdef LSU_MISALIGNED_SPLIT_EN
    w_go = w_legal;
`else
    w_go = w_legal && !w_misal;
`endif
  end

  // Outputs are registered from their next values, so a legal command issues mem_req the
  // cycle after start; only rejected commands spend a cycle in CHECK before FLT.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_req   = mem_req;
    w_nxt_we    = mem_we;
    w_nxt_addr  = mem_addr;
    w_nxt_be    = mem_be;
    w_nxt_wdata = mem_wdata;
    w_nxt_load  = load_data;
    w_nxt_done  = 1'b0;
    w_nxt_fault = 1'b0;
    w_latch     = 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
    w_cap_lo    = 1'b0;
`endif
    case (r_state)
      S_IDLE: if (start) begin
        w_latch = 1'b1;
        if (w_go) begin
          w_nxt_state = S_REQ;
          w_nxt_req   = 1'b1;
          w_nxt_we    = is_store;
          w_nxt_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
          w_nxt_be    = w_be_sh[3:0];
          w_nxt_wdata = w_wdata_sh[DATA_WIDTH-1:0];
        end else begin
          w_nxt_state = S_CHECK;
        end
      end
      S_CHECK: begin
        w_nxt_state = S_FLT;
        w_nxt_done  = 1'b1;
        w_nxt_fault = 1'b1;
      end
      S_REQ: if (mem_gnt) begin
        w_nxt_req   = 1'b0;
        w_nxt_state = S_WAIT;
      end
      S_WAIT: if (mem_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
        if (r_split) begin
          w_nxt_state = S_REQ2;
          w_nxt_req   = 1'b1;
          w_nxt_addr  = mem_addr + ADDR_WIDTH'(4);
          w_nxt_be    = r_be_hi;
          w_nxt_wdata = r_wdata_hi;
          w_cap_lo    = 1'b1;
        end else
`endif
        begin
          w_nxt_state = S_FIN;
          w_nxt_done  = 1'b1;
          if (!r_is_store) w_nxt_load = lsu_extend({32'b0, mem_rdata}, r_off, r_funct3);
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_REQ2: if (mem_gnt) begin
        w_nxt_req   = 1'b0;
        w_nxt_state = S_WAIT2;
      end
      S_WAIT2: if (mem_rvalid) begin
        w_nxt_state = S_FIN;
        w_nxt_done  = 1'b1;
        if (!r_is_store) w_nxt_load = lsu_extend({mem_rdata, r_rdata_lo}, r_off, r_funct3);
      end
`endif
      S_FIN, S_FLT: w_nxt_state = S_IDLE;
      default:      w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
      load_data <= '0;
    end else begin
      busy      <= (w_nxt_state != S_IDLE);
      done      <= w_nxt_done;
      fault     <= w_nxt_fault;
      mem_req   <= w_nxt_req;
      mem_we    <= w_nxt_we;
      mem_addr  <= w_nxt_addr;
      mem_be    <= w_nxt_be;
      mem_wdata <= w_nxt_wdata;
      load_data <= w_nxt_load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'b000;
      r_off      <= 2'b00;
`ifdef LSU_MISALIGNED_SPLIT_EN
      r_split    <= 1'b0;
      r_be_hi    <= 4'b0000;
      r_wdata_hi <= '0;
      r_rdata_lo <= '0;
`endif
    end else begin
      if (w_latch) begin
        r_is_store <= is_store;
        r_funct3   <= funct3;
        r_off      <= w_off;
`ifdef LSU_MISALIGNED_SPLIT_EN
        r_split    <= w_misal;
        r_be_hi    <= w_be_sh[7:4];
        r_wdata_hi <= w_wdata_sh[63:32];
`endif
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      if (w_cap_lo) r_rdata_lo <= mem_rdata;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_controller.sv
`default_nettype none
// tb_lsu_mem_controller: directed vectors with hand-computed expectations for lsu_mem_controller.
module tb_lsu_mem_controller;
  logic        clk = 1'b0;
  logic        rst, start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        busy, done, fault, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  lsu_mem_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered in a cycle where mem_req should be up; returns in the cycle after rvalid.
  task automatic serve(input string tag, input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic e_we, input logic [31:0] e_wdata, input int gnt_delay,
                       input logic early_rv, input logic [31:0] rdata);
    chk({tag, " req"}, mem_req, 1);
    chk({tag, " addr"}, mem_addr, e_addr);
    chk({tag, " be"}, mem_be, e_be);
    chk({tag, " we"}, mem_we, e_we);
    chk({tag, " wdata"}, mem_wdata, e_wdata);
    for (int i = 0; i < gnt_delay; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      @(negedge clk);
      chk({tag, " hold req"}, mem_req, 1);
      chk({tag, " hold addr"}, mem_addr, e_addr);
      chk({tag, " hold be"}, mem_be, e_be);
      chk({tag, " hold wdata"}, mem_wdata, e_wdata);
    end
    mem_gnt = 1'b1;
    mem_rvalid = early_rv; mem_rdata = 32'hDEAD_0000;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk({tag, " req dropped"}, mem_req, 0);
    chk({tag, " no early done"}, done, 0);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0; store_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);        chk("rst done", done, 0);
    chk("rst fault", fault, 0);      chk("rst req", mem_req, 0);
    chk("rst we", mem_we, 0);        chk("rst addr", mem_addr, 0);
    chk("rst be", mem_be, 0);        chk("rst wdata", mem_wdata, 0);
    chk("rst load", load_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // LB from the top byte lane: done at T3, busy T1..T3
    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
    chk("lb busy T1", busy, 1);
    serve("lb", 32'h0000_1000, 4'b1000, 1'b0, 32'h0, 0, 1'b0, 32'h80FF_0000);
    chk("lb done", done, 1);         chk("lb fault", fault, 0);
    chk("lb busy T3", busy, 1);      chk("lb load", load_data, 32'hFFFF_FF80);
    @(negedge clk);
    chk("lb done drop", done, 0);    chk("lb busy drop", busy, 0);

    // LHU with a simultaneous gnt+rvalid that must be ignored
    issue(1'b0, 3'b101, 32'h0000_2002, 32'h0);
    serve("lhu", 32'h0000_2000, 4'b1100, 1'b0, 32'h0, 0, 1'b1, 32'hBA98_1234);
    chk("lhu done", done, 1);        chk("lhu load", load_data, 32'h0000_BA98);
    @(negedge clk);

    // LH, then start during the done cycle must be dropped
    issue(1'b0, 3'b001, 32'h0000_2002, 32'h0);
    serve("lh", 32'h0000_2000, 4'b1100, 1'b0, 32'h0, 0, 1'b0, 32'hBA98_1234);
    chk("lh done", done, 1);         chk("lh load", load_data, 32'hFFFF_BA98);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h7000;
    @(negedge clk);
    start = 1'b0;
    chk("start@done busy", busy, 0); chk("start@done req", mem_req, 0);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stray rv idle done", done, 0);
    chk("stray rv idle busy", busy, 0);

    // SB with grant delayed three cycles, stray rvalids during REQ
    issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB);
    serve("sb", 32'h0000_3000, 4'b0010, 1'b1, 32'h0000_AB00, 3, 1'b0, 32'h0);
    chk("sb done", done, 1);         chk("sb fault", fault, 0);
    chk("sb load kept", load_data, 32'hFFFF_BA98);
    @(negedge clk);

`ifndef LSU_MISALIGNED_SPLIT_EN
    issue(1'b0, 3'b010, 32'h0000_4002, 32'h0);
    chk("mis lw req T1", mem_req, 0); chk("mis lw busy T1", busy, 1);
    chk("mis lw done T1", done, 0);
    @(negedge clk);
    chk("mis lw done", done, 1);     chk("mis lw fault", fault, 1);
    chk("mis lw req", mem_req, 0);   chk("mis lw load kept", load_data, 32'hFFFF_BA98);
    @(negedge clk);
    chk("mis lw done drop", done, 0); chk("mis lw fault drop", fault, 0);
    chk("mis lw busy drop", busy, 0);
`else
    issue(1'b0, 3'b010, 32'h0000_4002, 32'h0);
    serve("split lw a1", 32'h0000_4000, 4'b1100, 1'b0, 32'h0, 0, 1'b0, 32'h5678_ABCD);
    serve("split lw a2", 32'h0000_4004, 4'b0011, 1'b0, 32'h0, 1, 1'b0, 32'hEF01_1234);
    chk("split lw done", done, 1);   chk("split lw fault", fault, 0);
    chk("split lw load", load_data, 32'h1234_5678);
    @(negedge clk);
    issue(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF);
    serve("split sh a1", 32'hFFFF_FFFC, 4'b1000, 1'b1, 32'hEF00_0000, 0, 1'b0, 32'h0);
    serve("split sh a2", 32'h0000_0000, 4'b0001, 1'b1, 32'h0000_00BE, 0, 1'b0, 32'h0);
    chk("split sh done", done, 1);
    @(negedge clk);
`endif

    // Store with a load-only funct3 is illegal in both builds
    issue(1'b1, 3'b100, 32'h0000_5000, 32'h11);
    chk("ill st req T1", mem_req, 0);
    @(negedge clk);
    chk("ill st done", done, 1);     chk("ill st fault", fault, 1);
    @(negedge clk);

    // Reset while waiting for rvalid aborts without done
    issue(1'b0, 3'b010, 32'h0000_6000, 32'h0);
    chk("abort req", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("abort busy in wait", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 0);      chk("abort addr", mem_addr, 0);
    chk("abort be", mem_be, 0);      chk("abort load", load_data, 0);
    chk("abort req", mem_req, 0);
    @(negedge clk);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("abort no done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort idle done", done, 0); chk("abort idle busy", busy, 0);

    issue(1'b0, 3'b010, 32'h0000_0000, 32'h0);
    serve("lw0", 32'h0000_0000, 4'b1111, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
    chk("lw0 done", done, 1);        chk("lw0 load", load_data, 32'hDEAD_BEEF);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
